// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Also holds the round-robin pick function used by dm_rr_arb.
package dm_arb_pkg;

    localparam int DM_DATA_MEM_SIZE = 32;
    localparam int WORD_BYTES       = 4;
    localparam int NUM_REQ          = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } dm_state_e;

    typedef logic req_id_t;

    // On a tie, hand the grant to whoever did not win last time.
    function automatic req_id_t rr_pick(input logic [NUM_REQ-1:0] req, input req_id_t last);
        if (req[0] && req[1]) rr_pick = ~last;
        else if (req[1])      rr_pick = 1'b1;
        else                  rr_pick = 1'b0;
    endfunction

endpackage

// File: rtl/dm_rr_arb.sv
// Two-way round-robin picker with its last-grant pointer.
// The pointer resets to 1, so requester 0 wins the first tie.
module dm_rr_arb
    import dm_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_en,
    output logic               o_gnt,
    output req_id_t            o_gnt_id
);

    req_id_t r_last;

    assign o_gnt    = i_en && (|i_req);
    assign o_gnt_id = rr_pick(i_req, r_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_last <= 1'b1;
        else if (o_gnt) r_last <= o_gnt_id;
    end

endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates the CPU data port (0) and the loader (1) onto one data memory,
// one transaction per three cycles. Define DM_ARB_BOUNDS_CHECK_EN for range checking.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int DATA_MEM_SIZE = DM_DATA_MEM_SIZE,
    parameter int ADDR_W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [31:0]       wdata0,
    output logic              ack0,
    output logic [31:0]       rdata0,
    output logic              err0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata1,
    output logic              ack1,
    output logic [31:0]       rdata1,
    output logic              err1,
    output logic [31:0]       MemAddr,
    output logic [31:0]       MemWriteData,
    output logic              MemWrite,
    input  logic [31:0]       MemReadData,
    output logic              busy
);

    dm_state_e r_state, w_state_nxt;

    logic [NUM_REQ-1:0]             w_req, w_we;
    logic [NUM_REQ-1:0][ADDR_W-1:0] w_addr;
    logic [NUM_REQ-1:0][31:0]       w_wdata;
    logic                           w_gnt;
    req_id_t                        w_gnt_id;
    logic [ADDR_W-1:0]              w_sel_addr;
    logic                           w_oob;

    req_id_t                  r_owner;
    logic                     r_we;
    logic                     r_err;
    logic [31:0]              r_mem_addr;
    logic [31:0]              r_mem_wdata;
    logic [NUM_REQ-1:0][31:0] r_rdata;

    assign w_req   = {req1, req0};
    assign w_we    = {we1, we0};
    assign w_addr  = {addr1, addr0};
    assign w_wdata = {wdata1, wdata0};

    dm_rr_arb u_rr_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (w_req),
        .i_en     (r_state == ST_IDLE),
        .o_gnt    (w_gnt),
        .o_gnt_id (w_gnt_id)
    );

    assign w_sel_addr = w_addr[w_gnt_id];

`ifdef DM_ARB_BOUNDS_CHECK_EN
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DATA_MEM_SIZE - WORD_BYTES);
    // The whole word must fit, so the last legal byte address is SIZE-4.
    assign w_oob = (w_sel_addr > ADDR_LIMIT);
`else
    assign w_oob = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_gnt) w_state_nxt = ST_ACCESS;
            ST_ACCESS: w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Request capture; MemAddr/MemWriteData hold between grants.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner     <= 1'b0;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_gnt) begin
            r_owner     <= w_gnt_id;
            r_we        <= w_we[w_gnt_id];
            r_err       <= w_oob;
            r_mem_addr  <= 32'(w_sel_addr);
            r_mem_wdata <= w_wdata[w_gnt_id];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (r_state == ST_ACCESS) begin
            r_rdata[r_owner] <= (r_we || r_err) ? 32'd0 : MemReadData;
        end
    end

    assign MemAddr      = r_mem_addr;
    assign MemWriteData = r_mem_wdata;
    assign MemWrite     = (r_state == ST_ACCESS) && r_we && !r_err;
    assign busy         = (r_state != ST_IDLE);

    assign ack0   = (r_state == ST_RESP) && (r_owner == 1'b0);
    assign ack1   = (r_state == ST_RESP) && (r_owner == 1'b1);
    assign err0   = ack0 && r_err;
    assign err1   = ack1 && r_err;
    assign rdata0 = r_rdata[0];
    assign rdata1 = r_rdata[1];

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter with a byte-wide big-endian memory model.
// Expectations follow DM_ARB_BOUNDS_CHECK_EN when it is defined.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [31:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
    logic        ack0, ack1, err0, err1, MemWrite, busy;
    logic [31:0] rdata0, rdata1, MemAddr, MemWriteData, MemReadData;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit          id;
        logic [31:0] rdata;
        bit          err;
    } exp_t;
    exp_t sb_q[$];

`ifdef DM_ARB_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    always #5 clk = ~clk;

    dm_arbiter #(.DATA_MEM_SIZE(32), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .rdata0(rdata0), .err0(err0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .rdata1(rdata1), .err1(err1),
        .MemAddr(MemAddr), .MemWriteData(MemWriteData), .MemWrite(MemWrite),
        .MemReadData(MemReadData), .busy(busy)
    );

    // Memory model: combinational big-endian read, commit on falling edge.
    logic [7:0]  mem [0:31] = '{default: 8'h00};
    logic [31:0] wa;

    for (genvar k = 0; k < 4; k++) begin : g_rd
        logic [31:0] a;
        assign a = MemAddr + 32'(k);
        assign MemReadData[31-8*k -: 8] = (a < 32) ? mem[a[4:0]] : 8'h00;
    end

    always @(negedge clk) begin
        if (MemWrite) begin
            for (int k = 0; k < 4; k++) begin
                wa = MemAddr + 32'(k);
                if (wa < 32) mem[wa[4:0]] = MemWriteData[31-8*k -: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every ack must match the oldest pending expectation.
    always @(negedge clk) begin
        if (ack0 || ack1) begin
            chk("ack_onehot", 32'(ack0 & ack1), 32'd0);
            chk("sb_pending", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("ack_id", 32'(ack1), 32'(e.id));
                chk("rdata", ack1 ? rdata1 : rdata0, e.rdata);
                chk("err", 32'(ack1 ? err1 : err0), 32'(e.err));
            end
        end
    end

    task automatic drive(input bit id, input bit r, input bit we, input logic [31:0] a, input logic [31:0] d);
        if (id) begin req1 = r; we1 = we; addr1 = a; wdata1 = d; end
        else    begin req0 = r; we0 = we; addr0 = a; wdata0 = d; end
    endtask

    task automatic txn(input bit id, input bit we, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input bit exp_err, input bit exp_mw);
        int lat;
        lat = 0;
        @(negedge clk);
        drive(id, 1'b1, we, a, d);
        sb_q.push_back('{id, exp_rd, exp_err});
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("memwrite", 32'(MemWrite), 32'(exp_mw));
                chk("busy_access", 32'(busy), 32'd1);
            end
            if ((id ? ack1 : ack0) == 1'b1) begin
                lat = c;
                break;
            end
        end
        chk("ack_latency", 32'(lat), 32'd2);
        drive(id, 1'b0, 1'b0, a, d);
    endtask

    initial begin
        int acks;
        repeat (2) @(negedge clk);
        chk("rst_ack0", 32'(ack0), 0);
        chk("rst_ack1", 32'(ack1), 0);
        chk("rst_memwrite", 32'(MemWrite), 0);
        chk("rst_memaddr", MemAddr, 0);
        chk("rst_memwdata", MemWriteData, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        chk("rst_err0", 32'(err0), 0);
        chk("rst_err1", 32'(err1), 0);
        rst_n = 1'b1;

        // Write then read back through the other port.
        txn(1'b0, 1'b1, 32'd4, 32'hDEADBEEF, 32'd0, 1'b0, 1'b1);
        chk("mem_4_7", {mem[4], mem[5], mem[6], mem[7]}, 32'hDEADBEEF);
        txn(1'b1, 1'b0, 32'd4, 32'd0, 32'hDEADBEEF, 1'b0, 1'b0);
        txn(1'b1, 1'b1, 32'd0, 32'h01020304, 32'd0, 1'b0, 1'b1);
        @(negedge clk);
        chk("idle_memaddr_hold", MemAddr, 32'd0);
        chk("idle_memwdata_hold", MemWriteData, 32'h01020304);
        chk("idle_memwrite", 32'(MemWrite), 0);
        chk("idle_busy", 32'(busy), 0);

        // Fresh reset, then both requesters held high: grants 0,1,0,1.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 32'd4, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 4; i++) sb_q.push_back('{bit'(i % 2), (i % 2) ? 32'h01020304 : 32'hDEADBEEF, 1'b0});
        acks = 0;
        for (int c = 0; c < 20 && acks < 4; c++) begin
            @(negedge clk);
            if (ack0 || ack1) acks++;
        end
        chk("rr_ack_count", 32'(acks), 32'd4);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

        // Request withdrawn before it is sampled: no access at all.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'd16, 32'hFFFFFFFF);
        #2 drive(1'b0, 1'b0, 1'b0, 32'd16, 32'hFFFFFFFF);
        repeat (3) @(negedge clk);
        chk("withdraw_busy", 32'(busy), 0);
        chk("withdraw_mem16", {mem[16], mem[17], mem[18], mem[19]}, 32'd0);

        // Reset during the ACCESS cycle of a write aborts it.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'd8, 32'h12345678);
        @(posedge clk);
        #1;
        chk("abort_memwrite_pre", 32'(MemWrite), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_memwrite", 32'(MemWrite), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ack0", 32'(ack0), 0);
        drive(1'b0, 1'b0, 1'b0, 32'd8, 32'h12345678);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("abort_mem8", {mem[8], mem[9], mem[10], mem[11]}, 32'd0);
        txn(1'b1, 1'b0, 32'd8, 32'd0, 32'd0, 1'b0, 1'b0);

        // Range boundary: 30 is out of range when checking is on, 28 is the last legal word.
        txn(1'b0, 1'b1, 32'd30, 32'hCAFEF00D, 32'd0, BC, !BC);
        txn(1'b1, 1'b0, 32'd30, 32'd0, BC ? 32'd0 : 32'hCAFE0000, BC, 1'b0);
        txn(1'b0, 1'b0, 32'd28, 32'd0, BC ? 32'd0 : 32'h0000CAFE, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
